config_stream_sequencer: RTL and testbench
==========================================

# config_stream_sequencer

Wishbone-attached controller that streams a bitstream into the fabric's configuration shift chain and then pulses the latch-set strobe. Software writes a bit length, then pushes 32-bit words into a small FIFO. The block serialises the words MSB-first onto the chain, one bit per enabled clock, and fires the latch pulse once the last bit is shifted. It sits between the Caravel Wishbone bus and the `fpga` core's config tiles, alongside the GPIO mapping in the user wrapper.

## Interface
- `FIFO_DEPTH`, 4: word FIFO entries; power of two, ≥2.
- `CNT_W`, 20: width of the bit-length and remaining-bit counters.
- `LATCH_CYCLES`, 2: width of the `config_latch_o` pulse, in clocks; must be ≥1.
- `wb_clk_i` input 1: sole clock.
- `wb_rst_ni` input 1: asynchronous, active-low reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` input 1: Wishbone classic strobe, cycle and write-enable.
- `wbs_sel_i` input 4: byte selects. Ignored; all writes are full-word.
- `wbs_addr_i` input 32: bits [4:2] decode the register; other bits are ignored (external decode).
- `wbs_data_i` input 32: write data.
- `wbs_ack_o` output 1: single-cycle acknowledge.
- `wbs_data_o` output 32: read data; 0 when not acking.
- `config_en_o` output 1: shift enable to the chain.
- `config_data_o` output 1: serial config bit, valid while `config_en_o` is high.
- `config_latch_o` output 1: latch-set strobe.
- `busy_o` output 1: high in any state other than IDLE.
- `done_o` output 1: sticky done flag; mirrors STATUS.done.
- Reset value of every output: 0.

## Operation
- Register map, selected by `addr[4:2]`:
  - 0 CTRL (write only). Bit0 = start, bit1 = abort, bit2 = clear sticky flags. All bits are write-1 pulses; reads return 0.
  - 1 LEN (R/W). Total bit count, `CNT_W` bits. Upper bits read as 0.
  - 2 DATA (write only). Pushes one word into the FIFO.
  - 3 STATUS (read only). Bit0 busy, bit1 done, bit2 fifo_empty, bit3 fifo_full, bit4 overflow, bit5 len_err, bit6 starved, bits[15:8] fifo count.
  - 4 CHECKSUM (read only). See Configuration.
  - 5–7: reads return 0; writes are ignored.
- FSM states and transitions:
  - IDLE: on start with LEN≠0 → LOAD, and `remaining` = LEN. Start with LEN=0 sets len_err and stays in IDLE.
  - LOAD: if the FIFO is non-empty, pop into a 32-bit shift register, set bit index = 31, → SHIFT. If empty, stay and set starved.
  - SHIFT: each cycle drives `config_data_o` = sreg[31], `config_en_o` = 1, shifts sreg left and decrements `remaining`.
    - When `remaining` hits 1 → LATCH; trailing bits of the last word are discarded.
    - Otherwise, when the bit index hits 0 → LOAD.
  - LATCH: `config_latch_o` is high for `LATCH_CYCLES` cycles, then → IDLE. done is set on exit.
- Abort from any state: → IDLE, flush the FIFO, deassert all strobes, leave done unchanged.
- Start while busy is ignored.
- Start also clears done.
- A push while the FIFO is full is dropped and sets sticky overflow.
- A push is accepted in any state, including IDLE, to allow preloading.
- If a push and a pop happen in the same cycle with the FIFO full, both succeed.
- Sticky flags (done, overflow, len_err, starved) are cleared only by CTRL bit2 or by reset.

## Timing
- A Wishbone request is accepted on an edge with stb & cyc & !ack.
  - `wbs_ack_o` is high for exactly the next cycle.
  - Back-to-back accesses therefore take 2 cycles each.
  - The write side effect is applied at the accepting edge.
- Start accepted at edge k with the FIFO non-empty:
  - LOAD at k; SHIFT entered at k+1.
  - First `config_en_o` high in the cycle after k+1.
- All of `config_*_o`, `busy_o` and `done_o` are registered.
- Between words there is 1 idle cycle (the LOAD cycle) with `config_en_o` = 0, so a full word takes 33 cycles.
- Last shifted bit is followed by `config_latch_o` in the very next cycle.
- An asynchronous reset mid-stream forces all outputs to 0 immediately and empties the FIFO.

## Configuration
- `CONFIG_CHECKSUM_EN` defined:
  - A 32-bit running checksum updates on each shifted bit: chk ← {chk[30:0], chk[31]^bit}.
  - It is cleared on start and readable at CHECKSUM.
- Undefined: no checksum register is built, and CHECKSUM reads 0.

## Test plan
- LEN=8, push 0xA5000000, start → `config_data_o` sequence 1,0,1,0,0,1,0,1 on 8 consecutive `config_en_o` cycles, then `config_latch_o` high for 2 cycles, then done=1, busy=0.
- LEN=64, push 0xFFFFFFFF and 0x00000000, start → 32 ones, 1 gap cycle, 32 zeros; STATUS reads 0x06 (done, fifo_empty) at the end.
- Push 5 words with `FIFO_DEPTH`=4 while idle → overflow=1, fifo count=4. Write CTRL=0x4 → overflow=0.
- LEN=40, push 1 word, start → after 32 bits the block sits in LOAD with starved=1. Push 0x80000000 → remaining 8 bits are 1,0,0,0,0,0,0,0, then latch.
- Abort at bit 10 of a 32-bit stream → `config_en_o` low next cycle, no latch pulse, FIFO empty, done unchanged. LEN=0 start → len_err=1, busy stays 0.
- With `CONFIG_CHECKSUM_EN`: LEN=32, word 0x00000001 → CHECKSUM=0x00000001. Without it → CHECKSUM=0.

Source files
------------

// File: rtl/config_stream_sequencer.sv
// config_stream_sequencer: Wishbone-programmed serialiser that shifts a word FIFO MSB-first
// into the fabric config chain, then pulses the latch strobe. Define CONFIG_CHECKSUM_EN for a checksum register.

module config_stream_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 20,
  parameter int LATCH_CYCLES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_data_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_data_o,
  output logic        config_en_o,
  output logic        config_data_o,
  output logic        config_latch_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [LW-1:0] LAST_LATCH = LW'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} state_e;
  state_e state_q, state_d;

  logic             ack_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             accept, wr_acc;
  logic [2:0]       reg_sel;
  logic             start_p, abort_p, clr_p, push_p, start_go;
  logic [CNT_W-1:0] len_q, rem_q;
  logic [31:0]      sreg_q;
  logic [4:0]       bidx_q;
  logic [LW-1:0]    lcnt_q;
  logic             en_d, en_q, data_d, data_q, latch_d, latch_q;
  logic             busy_d, busy_q, done_d, done_q;
  logic             ovf_q, lenerr_q, starved_q;
  logic [31:0]      fifo_mem_q [FIFO_DEPTH];
  logic [AW:0]      wptr_q, rptr_q, fifo_cnt;
  logic             fifo_empty, fifo_full, pop, push_ok;
  logic [31:0]      chk_rd, status;
  logic             unused_bits;

  assign accept      = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign wr_acc      = accept & wbs_we_i;
  assign reg_sel     = wbs_addr_i[4:2];
  assign start_p     = wr_acc & (reg_sel == 3'd0) & wbs_data_i[0];
  assign abort_p     = wr_acc & (reg_sel == 3'd0) & wbs_data_i[1];
  assign clr_p       = wr_acc & (reg_sel == 3'd0) & wbs_data_i[2];
  assign push_p      = wr_acc & (reg_sel == 3'd2);
  assign start_go    = start_p & ~abort_p & (state_q == S_IDLE);
  assign unused_bits = ^{wbs_sel_i, wbs_addr_i[31:5], wbs_addr_i[1:0]};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_cnt   = wptr_q - rptr_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_C);
  assign pop        = (state_q == S_LOAD) & ~fifo_empty & ~abort_p;
  assign push_ok    = push_p & (~fifo_full | pop);

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) fifo_mem_q[wptr_q[AW-1:0]] <= wbs_data_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + (AW+1)'(1);
      if (abort_p)  rptr_q <= wptr_q;
      else if (pop) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_go && len_q != '0) state_d = S_LOAD;
      S_LOAD:  if (!fifo_empty) state_d = S_SHIFT;
      S_SHIFT: if (rem_q == CNT_W'(1)) state_d = S_LATCH;
               else if (bidx_q == '0) state_d = S_LOAD;
      S_LATCH: if (lcnt_q == LAST_LATCH) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_p) state_d = S_IDLE;
  end

  // Chain outputs lag the state by one clock so each shifted bit appears registered.
  always_comb begin
    en_d    = (state_q == S_SHIFT) & ~abort_p;
    data_d  = en_d & sreg_q[31];
    latch_d = (state_q == S_LATCH) & ~abort_p;
    busy_d  = (state_d != S_IDLE);
    done_d  = done_q;
    if (clr_p || start_go) done_d = 1'b0;
    if (state_q == S_LATCH && state_d == S_IDLE && !abort_p) done_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      en_q    <= 1'b0;
      data_q  <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q    <= en_d;
      data_q  <= data_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      len_q  <= '0;
      rem_q  <= '0;
      sreg_q <= '0;
      bidx_q <= '0;
      lcnt_q <= '0;
    end else begin
      if (wr_acc && reg_sel == 3'd1) len_q <= wbs_data_i[CNT_W-1:0];
      if (start_go)  rem_q <= len_q;
      else if (en_d) rem_q <= rem_q - CNT_W'(1);
      if (pop) begin
        sreg_q <= fifo_mem_q[rptr_q[AW-1:0]];
        bidx_q <= 5'd31;
      end else if (en_d) begin
        sreg_q <= {sreg_q[30:0], 1'b0};
        bidx_q <= bidx_q - 5'd1;
      end
      lcnt_q <= (state_q == S_LATCH) ? lcnt_q + LW'(1) : '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ovf_q     <= 1'b0;
      lenerr_q  <= 1'b0;
      starved_q <= 1'b0;
    end else begin
      if (clr_p) begin
        ovf_q     <= 1'b0;
        lenerr_q  <= 1'b0;
        starved_q <= 1'b0;
      end
      if (push_p && fifo_full && !pop)                    ovf_q     <= 1'b1;
      if (start_go && len_q == '0)                        lenerr_q  <= 1'b1;
      if (state_q == S_LOAD && fifo_empty && !abort_p)   starved_q <= 1'b1;
    end
  end

`ifdef CONFIG_CHECKSUM_EN
  logic [31:0] chk_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)    chk_q <= '0;
    else if (start_go) chk_q <= '0;
    else if (en_d)     chk_q <= {chk_q[30:0], chk_q[31] ^ sreg_q[31]};
  end

  assign chk_rd = chk_q;
`else
  assign chk_rd = '0;
`endif

  assign status = {16'd0, 8'(fifo_cnt), 1'b0, starved_q, lenerr_q, ovf_q,
                   fifo_full, fifo_empty, done_q, busy_q};

  always_comb begin
    rdata_d = '0;
    if (accept && !wbs_we_i) begin
      case (reg_sel)
        3'd1:    rdata_d = 32'(len_q);
        3'd3:    rdata_d = status;
        3'd4:    rdata_d = chk_rd;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= accept;
      rdata_q <= rdata_d;
    end
  end

  assign wbs_ack_o      = ack_q;
  assign wbs_data_o     = rdata_q;
  assign config_en_o    = en_q;
  assign config_data_o  = data_q;
  assign config_latch_o = latch_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_config_stream_sequencer.sv
// Self-checking bench for config_stream_sequencer: directed and random bitstreams compared
// against a word-list model of the expected serial stream, latch pulse and STATUS values.

module tb_config_stream_sequencer;
  localparam int LATCH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack, en, dat, latch, busy, done;
  logic [31:0] rdat;

  always #5 clk = ~clk;

  config_stream_sequencer #(
    .FIFO_DEPTH  (4),
    .CNT_W       (20),
    .LATCH_CYCLES(LATCH_CYCLES)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_addr_i    (adr),
    .wbs_data_i    (wdat),
    .wbs_ack_o     (ack),
    .wbs_data_o    (rdat),
    .config_en_o   (en),
    .config_data_o (dat),
    .config_latch_o(latch),
    .busy_o        (busy),
    .done_o        (done)
  );

  int checks = 0;
  int errors = 0;

  // Chain monitor: every enabled bit and every latch-high cycle, tagged by negedge index.
  bit bits_q[$];
  int en_at[$];
  int lat_at[$];
  int nc = 0;

  always @(negedge clk) begin
    nc++;
    if (en === 1'b1) begin
      bits_q.push_back(dat);
      en_at.push_back(nc);
    end
    if (latch === 1'b1) lat_at.push_back(nc);
  end

  logic [31:0] mw[$];
  int bb, lb, snc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb(input bit w, input int idx, input logic [31:0] wd, output logic [31:0] rd);
    int n;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = 32'(idx) << 2; wdat = wd;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (ack !== 1'b1 && n < 8);
    rd = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("wb_ack", {31'd0, ack}, 32'd1);
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    logic [31:0] dummy;
    wb(1'b1, idx, d, dummy);
  endtask

  task automatic rd(input int idx, output logic [31:0] d);
    wb(1'b0, idx, 32'd0, d);
  endtask

  task automatic push(input logic [31:0] w);
    wr(2, w);
    mw.push_back(w);
  endtask

  task automatic start_stream();
    bb = bits_q.size();
    lb = lat_at.size();
    wr(0, 32'd1);
    snc = nc;
  endtask

  function automatic bit mbit(input int i);
    logic [31:0] w;
    w = mw[i / 32];
    return w[31 - (i % 32)];
  endfunction

  function automatic logic [31:0] mchk(input int len);
    logic [31:0] c = '0;
    for (int i = 0; i < len; i++) c = {c[30:0], c[31] ^ mbit(i)};
    return c;
  endfunction

  task automatic wait_bits(input int n, input int lim);
    for (int k = 0; k < lim; k++) begin
      if (bits_q.size() >= bb + n) break;
      @(negedge clk);
    end
    chk("wait_bits", {31'd0, bits_q.size() >= bb + n}, 32'd1);
  endtask

  task automatic run_check(input string tag, input int len, input bit strict);
    int got, nl, bad, idx;
    logic [31:0] ow, ew, r, ec;
    for (int n = 0; n < len * 2 + 200; n++) begin
      if (done === 1'b1 && busy === 1'b0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk({tag, "_done"}, {30'd0, done, busy}, 32'd2);
    got = bits_q.size() - bb;
    chk({tag, "_nbits"}, got, len);
    for (int k = 0; k < (len + 31) / 32; k++) begin
      ow = '0; ew = '0;
      for (int j = 0; j < 32; j++) begin
        idx = k * 32 + j;
        if (idx < len) begin
          ew[31-j] = mbit(idx);
          if (idx < got) ow[31-j] = bits_q[bb + idx];
        end
      end
      chk({tag, "_bits"}, ow, ew);
    end
    nl = lat_at.size() - lb;
    chk({tag, "_nlatch"}, nl, LATCH_CYCLES);
    if (got > 0 && nl > 0) begin
      chk({tag, "_latch_follow"}, lat_at[lb] - en_at[bb + got - 1], 1);
      chk({tag, "_latch_contig"}, lat_at[lb + nl - 1] - lat_at[lb], LATCH_CYCLES - 1);
    end
    if (strict && got > 0) begin
      chk({tag, "_first_en"}, en_at[bb] - snc, 3);
      bad = 0;
      for (int k = 1; k < got; k++)
        if (en_at[bb + k] - en_at[bb + k - 1] != ((k % 32 == 0) ? 2 : 1)) bad++;
      chk({tag, "_spacing"}, bad, 0);
    end
    rd(4, r);
`ifdef CONFIG_CHECKSUM_EN
    ec = mchk(len);
`else
    ec = '0;
`endif
    chk({tag, "_checksum"}, r, ec);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int len, nw, got, bad;

    #3 rst_n = 1'b0;
    #20;
    chk("reset_outs", {26'd0, ack, en, dat, latch, busy, done}, 32'd0);
    chk("reset_rdata", rdat, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    rd(3, r);
    chk("reset_status", r, 32'h04);
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'd0, ack}, 32'd0);
    chk("rdata_idle", rdat, 32'd0);

    // LEN=8, 0xA5000000
    mw.delete();
    wr(1, 8);
    push(32'hA500_0000);
    start_stream();
    run_check("len8", 8, 1'b1);
    rd(3, r);
    chk("len8_status", r, 32'h06);

    // LEN=64, ones then zeros
    mw.delete();
    wr(1, 64);
    push(32'hFFFF_FFFF);
    push(32'h0000_0000);
    start_stream();
    run_check("len64", 64, 1'b1);
    rd(3, r);
    chk("len64_status", r, 32'h06);

    // LEN=32, word 1: checksum 1 when built
    mw.delete();
    wr(1, 32);
    push(32'h0000_0001);
    start_stream();
    run_check("chk32", 32, 1'b1);

    // Overflow while idle
    for (int k = 0; k < 5; k++) wr(2, $urandom);
    rd(3, r);
    chk("ovf_status", r, 32'h41A);
    wr(0, 32'h4);
    rd(3, r);
    chk("ovf_cleared", r, 32'h408);
    wr(0, 32'h2);
    rd(3, r);
    chk("ovf_flushed", r, 32'h04);

    // Starvation after the first word
    mw.delete();
    wr(1, 40);
    push($urandom);
    start_stream();
    wait_bits(32, 200);
    repeat (3) @(negedge clk);
    rd(3, r);
    chk("starved_status", r, 32'h45);
    chk("starved_en_low", {31'd0, en}, 32'd0);
    push(32'h8000_0000);
    run_check("starved", 40, 1'b0);

    // Abort around bit 10
    wr(0, 32'h4);
    mw.delete();
    wr(1, 64);
    push($urandom);
    push($urandom);
    start_stream();
    wait_bits(10, 100);
    wr(0, 32'h2);
    chk("abort_outs", {29'd0, en, latch, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_nlatch", lat_at.size() - lb, 0);
    got = bits_q.size() - bb;
    chk("abort_partial", {31'd0, got >= 10 && got < 32}, 32'd1);
    bad = 0;
    for (int i = 0; i < got; i++) if (bits_q[bb + i] != mbit(i)) bad++;
    chk("abort_prefix", bad, 0);
    rd(3, r);
    chk("abort_status", r, 32'h04);

    // LEN=0 start, LEN register width, unmapped reads
    wr(1, 0);
    wr(0, 32'h1);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    rd(3, r);
    chk("len0_status", r, 32'h24);
    wr(1, 32'hFFFF_FFFF);
    rd(1, r);
    chk("len_readback", r, 32'h000F_FFFF);
    rd(0, r);
    chk("ctrl_read", r, 32'd0);
    rd(6, r);
    chk("unmapped_read", r, 32'd0);
    wr(0, 32'h4);
    rd(3, r);
    chk("clear_status", r, 32'h04);

    // Random streams
    for (int t = 0; t < 4; t++) begin
      len = $urandom_range(1, 128);
      nw = (len + 31) / 32;
      mw.delete();
      wr(1, len);
      for (int k = 0; k < nw; k++) push($urandom);
      start_stream();
      run_check("rand", len, 1'b1);
    end

    // Asynchronous reset mid-stream
    mw.delete();
    wr(1, 32);
    push($urandom);
    push($urandom);
    start_stream();
    wait_bits(5, 100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", {26'd0, ack, en, dat, latch, busy, done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    rd(3, r);
    chk("arst_status", r, 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
